eth_header_writer: RTL and testbench
====================================

ETH_HEADER_WRITER -- requirements
Module: eth_header_writer

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, tuser width.
REQ-003 SHALL have parameter DST_PORT_POS, default 24, LSB of destination-port field in tuser.
REQ-004 SHALL have parameter NUM_QUEUES, default 8, destination-port bitmap width.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port hdr_dst_mac  in  48  MAC written to tdata[47:0] of first beat.
REQ-008 SHALL have port hdr_src_mac  in  48  MAC written to tdata[95:48] of first beat.
REQ-009 SHALL have port hdr_dst_port  in  NUM_QUEUES  bitmap written to tuser[DST_PORT_POS+NUM_QUEUES-1:DST_PORT_POS].
REQ-010 SHALL have port hdr_valid  in  1  header fields valid.
REQ-011 SHALL have port hdr_ready  out  1  header accepted when hdr_valid && hdr_ready.
REQ-012 SHALL have ports s_axis_tdata/tkeep/tuser/tlast/tvalid  in  DATA/DATA÷8/TUSER/1/1  input stream.
REQ-013 SHALL have port s_axis_tready  out  1  input backpressure.
REQ-014 SHALL have ports m_axis_tdata/tkeep/tuser/tlast/tvalid  out  DATA/DATA÷8/TUSER/1/1  output stream.
REQ-015 SHALL have port m_axis_tready  in  1  output backpressure.
REQ-016 SHALL have port pkt_count  out  32  packets fully emitted since reset.

Function
REQ-017 SHALL implement states WAIT_HDR, FIRST_WORD, BODY.
REQ-018 WAIT_HDR: hdr_ready=1, s_axis_tready=0; on hdr_valid, latch three header fields, go FIRST_WORD.
REQ-019 FIRST_WORD/BODY: hdr_ready=0; s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-020 Input beat accepted iff s_axis_tvalid && s_axis_tready; only accepted beats advance state.
REQ-021 FIRST_WORD beat: emit tdata with [95:0] replaced by {latched src_mac, latched dst_mac}, tuser dst-port field replaced by latched bitmap; all other bits, tkeep, tlast unchanged.
REQ-022 FIRST_WORD accepted with tlast=0 -> BODY; with tlast=1 -> WAIT_HDR.
REQ-023 BODY beats pass unmodified; accepted beat with tlast=1 -> WAIT_HDR.
REQ-024 Output is one register stage: accepted beat appears on m_axis_* next cycle; latency exactly 1 cycle with m_axis_tready=1.
REQ-025 m_axis_* SHALL hold stable while m_axis_tvalid && !m_axis_tready; m_axis_tvalid clears only when beat taken and no new beat accepted.
REQ-026 Simultaneous output handshake and input acceptance SHALL sustain one beat/cycle with no bubble.
REQ-027 pkt_count SHALL increment by 1 on each output handshake with m_axis_tlast=1; wraps 0xFFFFFFFF -> 0.
REQ-028 Header fields presented while not in WAIT_HDR SHALL be ignored (not latched).
REQ-029 s_axis_tvalid with tkeep all-zero SHALL still be forwarded unchanged (no filtering).

Reset
REQ-030 On reset: state=WAIT_HDR, m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, pkt_count=0, latched header=0.
REQ-031 Reset mid-packet SHALL discard the in-flight output beat and remaining packet; post-reset first accepted beat is treated as FIRST_WORD after a new header.
REQ-032 During reset cycle hdr_ready=0 and s_axis_tready=0.

Structure
REQ-033 State encoding and MAC field offsets (0, 48) SHALL live in shared package nf10_eth_pkg alongside the parser's constants.
REQ-034 Output register stage SHALL be a sub-module axis_reg_slice (parameterised by data/tuser width); header FSM stays in eth_header_writer.

Verification
REQ-035 Header dst=0x0A0B0C0D0E0F, src=0x112233445566, port=0x04; 3-beat packet -> beat0 tdata[95:0]=0x1122334455660A0B0C0D0E0F, tuser[31:24]=0x04; beats1-2 bit-identical; pkt_count=1.
REQ-036 Single-beat packet (tlast on first beat) -> header rewritten, state back to WAIT_HDR, next packet needs new hdr_valid.
REQ-037 m_axis_tready toggled 1/0 each cycle over 8-beat packet -> no beat lost/duplicated; outputs stable while stalled.
REQ-038 Back-to-back two packets, m_axis_tready=1 -> body beats 1 cycle latency, one idle cycle per header accept in WAIT_HDR.
REQ-039 Reset asserted on beat 2 of 5 -> m_axis_tvalid=0 next cycle, pkt_count=0, hdr_ready=1 after reset deasserts.
REQ-040 Preload pkt_count near wrap via 2^32-1 packets (or forced) -> next packet yields pkt_count=0.

Source files
------------

// File: rtl/nf10_eth_pkg.sv
// Shared Ethernet constants for the NetFPGA-10G header parser and header writer.
// State codes are plain constants so older tools and netlists can share them.
package nf10_eth_pkg;

  localparam int MAC_WIDTH       = 48;
  localparam int DST_MAC_POS     = 0;
  localparam int SRC_MAC_POS     = 48;
  localparam int ETHERTYPE_POS   = 96;
  localparam int ETHERTYPE_WIDTH = 16;

  localparam logic [1:0] ST_WAIT_HDR   = 2'd0;
  localparam logic [1:0] ST_FIRST_WORD = 2'd1;
  localparam logic [1:0] ST_BODY       = 2'd2;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice: full throughput, outputs driven from flops.
module axis_reg_slice #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [TUSER_WIDTH-1:0]    s_tuser,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic [TUSER_WIDTH-1:0]    m_tuser,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready
);

  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
  logic [TUSER_WIDTH-1:0]  tuser_q, tuser_d;
  logic                    tlast_q, tlast_d;
  logic                    valid_q, valid_d;
  logic                    load;

  // The slot may be refilled in the same cycle its current beat is taken.
  assign s_tready = !valid_q || m_tready;
  assign load     = s_tvalid && s_tready;

  always_comb begin
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    valid_d = valid_q;
    if (load) begin
      tdata_d = s_tdata;
      tkeep_d = s_tkeep;
      tuser_d = s_tuser;
      tlast_d = s_tlast;
      valid_d = 1'b1;
    end else if (m_tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_q <= '0;
      tkeep_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tuser_q <= tuser_d;
      tlast_q <= tlast_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tuser  = tuser_q;
  assign m_tlast  = tlast_q;
  assign m_tvalid = valid_q;

endmodule

// File: rtl/eth_header_writer.sv
// Ethernet header writer: overwrites MACs and the destination-port bitmap on the
// first beat of each packet and forwards the rest through one register stage.
module eth_header_writer
  import nf10_eth_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24,
  parameter int NUM_QUEUES           = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [47:0]                        hdr_dst_mac,
  input  logic [47:0]                        hdr_src_mac,
  input  logic [NUM_QUEUES-1:0]              hdr_dst_port,
  input  logic                               hdr_valid,
  output logic                               hdr_ready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [31:0]                        pkt_count
);

  logic [1:0]                      state_q, state_d;
  logic [MAC_WIDTH-1:0]            dst_mac_q, dst_mac_d;
  logic [MAC_WIDTH-1:0]            src_mac_q, src_mac_d;
  logic [NUM_QUEUES-1:0]           dst_port_q, dst_port_d;
  logic [31:0]                     pkt_count_q, pkt_count_d;
  logic                            in_pkt;
  logic                            slice_ready;
  logic                            beat_acc;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  fwd_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] fwd_tuser;

  // Both readies are forced low while reset is held so nothing is taken mid-reset.
  assign in_pkt        = (state_q != ST_WAIT_HDR);
  assign hdr_ready     = !in_pkt && !reset;
  assign s_axis_tready = in_pkt && slice_ready && !reset;
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d    = state_q;
    dst_mac_d  = dst_mac_q;
    src_mac_d  = src_mac_q;
    dst_port_d = dst_port_q;
    case (state_q)
      ST_WAIT_HDR: begin
        if (hdr_valid && hdr_ready) begin
          dst_mac_d  = hdr_dst_mac;
          src_mac_d  = hdr_src_mac;
          dst_port_d = hdr_dst_port;
          state_d    = ST_FIRST_WORD;
        end else begin
          state_d = ST_WAIT_HDR;
        end
      end
      ST_FIRST_WORD: begin
        if (beat_acc) begin
          state_d = s_axis_tlast ? ST_WAIT_HDR : ST_BODY;
        end else begin
          state_d = ST_FIRST_WORD;
        end
      end
      ST_BODY: begin
        if (beat_acc && s_axis_tlast) begin
          state_d = ST_WAIT_HDR;
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        state_d = ST_WAIT_HDR;
      end
    endcase
  end

  always_comb begin
    fwd_tdata = s_axis_tdata;
    fwd_tuser = s_axis_tuser;
    if (state_q == ST_FIRST_WORD) begin
      fwd_tdata[DST_MAC_POS +: MAC_WIDTH]    = dst_mac_q;
      fwd_tdata[SRC_MAC_POS +: MAC_WIDTH]    = src_mac_q;
      fwd_tuser[DST_PORT_POS +: NUM_QUEUES]  = dst_port_q;
    end else begin
      fwd_tdata = s_axis_tdata;
      fwd_tuser = s_axis_tuser;
    end
  end

  // A packet counts once its last beat leaves, not when it enters.
  always_comb begin
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_HDR;
      dst_mac_q   <= '0;
      src_mac_q   <= '0;
      dst_port_q  <= '0;
      pkt_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      dst_mac_q   <= dst_mac_d;
      src_mac_q   <= src_mac_d;
      dst_port_q  <= dst_port_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;

  axis_reg_slice #(
    .DATA_WIDTH  (C_S_AXIS_DATA_WIDTH),
    .TUSER_WIDTH (C_S_AXIS_TUSER_WIDTH)
  ) u_out_slice (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (fwd_tdata),
    .s_tkeep  (s_axis_tkeep),
    .s_tuser  (fwd_tuser),
    .s_tlast  (s_axis_tlast),
    .s_tvalid (s_axis_tvalid && in_pkt),
    .s_tready (slice_ready),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tuser  (m_axis_tuser),
    .m_tlast  (m_axis_tlast),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_eth_header_writer.sv
// Self-checking bench for eth_header_writer: directed vector table, hand-written
// corner sequences and randomized traffic against a packet-level scoreboard.
module tb_eth_header_writer;

  localparam int DW  = 256;
  localparam int KW  = DW / 8;
  localparam int UW  = 128;
  localparam int DPP = 24;
  localparam int NQ  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [47:0]   hdr_dst_mac = 48'd0;
  logic [47:0]   hdr_src_mac = 48'd0;
  logic [NQ-1:0] hdr_dst_port = '0;
  logic          hdr_valid = 1'b0;
  logic          hdr_ready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   pkt_count;

  eth_header_writer #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .DST_PORT_POS         (DPP),
    .NUM_QUEUES           (NQ)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hdr_dst_mac   (hdr_dst_mac),
    .hdr_src_mac   (hdr_src_mac),
    .hdr_dst_port  (hdr_dst_port),
    .hdr_valid     (hdr_valid),
    .hdr_ready     (hdr_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic          tlast;
    bit            first;
  } beat_t;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [7:0]  port;
    int          nb;
    int          mode;
    bit          noise;
    bit          zk;
    logic [95:0] exp_low96;
    logic [7:0]  exp_port;
  } vec_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_pkts = 0;
  int          rdy_mode = 0;
  bit          mon_en = 1'b1;
  bit          cap_seen = 1'b0;
  logic [95:0] cap_low96 = '0;
  logic [7:0]  cap_port = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_uw();
    logic [UW-1:0] r;
    for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  // Output-ready pattern: 0 always ready, 1 toggling, otherwise random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = !m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard, stall-stability and one-cycle-latency monitor.
  initial begin
    beat_t         e;
    bit            stall_prev = 1'b0;
    bit            lat_pend = 1'b0;
    logic [DW-1:0] sv_data;
    logic [KW-1:0] sv_keep;
    logic [UW-1:0] sv_user;
    logic          sv_last;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        stall_prev = 1'b0;
        lat_pend   = 1'b0;
      end else begin
        if (lat_pend) chk("latency_valid", DW'(m_axis_tvalid), DW'(1'b1));
        if (stall_prev) begin
          chk("stall_valid", DW'(m_axis_tvalid), DW'(1'b1));
          chk("stall_tdata", m_axis_tdata, sv_data);
          chk("stall_tkeep", DW'(m_axis_tkeep), DW'(sv_keep));
          chk("stall_tuser", DW'(m_axis_tuser), DW'(sv_user));
          chk("stall_tlast", DW'(m_axis_tlast), DW'(sv_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_tdata", m_axis_tdata, e.tdata);
            chk("out_tkeep", DW'(m_axis_tkeep), DW'(e.tkeep));
            chk("out_tuser", DW'(m_axis_tuser), DW'(e.tuser));
            chk("out_tlast", DW'(m_axis_tlast), DW'(e.tlast));
            if (e.first) begin
              cap_seen  = 1'b1;
              cap_low96 = m_axis_tdata[95:0];
              cap_port  = m_axis_tuser[DPP +: NQ];
            end
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        sv_data    = m_axis_tdata;
        sv_keep    = m_axis_tkeep;
        sv_user    = m_axis_tuser;
        sv_last    = m_axis_tlast;
        lat_pend   = s_axis_tvalid && s_axis_tready;
      end
    end
  end

  task automatic send_packet(input logic [47:0] dst, input logic [47:0] src, input logic [7:0] port,
                             input int nb, input bit gaps, input bit noise, input bit zk);
    beat_t e;
    int    to;
    @(posedge clk);
    #1;
    hdr_dst_mac  = dst;
    hdr_src_mac  = src;
    hdr_dst_port = port;
    hdr_valid    = 1'b1;
    @(negedge clk);
    to = 0;
    while (!hdr_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("hdr_handshake", DW'(hdr_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    hdr_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      e.tdata = rand_dw();
      e.tkeep = (zk && b == nb - 1) ? '0 : KW'($urandom);
      e.tuser = rand_uw();
      e.tlast = (b == nb - 1);
      e.first = (b == 0);
      s_axis_tdata  = e.tdata;
      s_axis_tkeep  = e.tkeep;
      s_axis_tuser  = e.tuser;
      s_axis_tlast  = e.tlast;
      s_axis_tvalid = 1'b1;
      if (noise && b < nb - 1) begin
        hdr_valid    = 1'b1;
        hdr_dst_mac  = rand48();
        hdr_src_mac  = rand48();
        hdr_dst_port = NQ'($urandom);
      end else begin
        hdr_valid = 1'b0;
      end
      if (b == 0) begin
        e.tdata[47:0]       = dst;
        e.tdata[95:48]      = src;
        e.tuser[DPP +: NQ]  = port;
      end
      exp_q.push_back(e);
      @(negedge clk);
      if (noise && b < nb - 1) chk("hdr_ignored_ready", DW'(hdr_ready), DW'(1'b0));
      to = 0;
      while (!s_axis_tready && to < 200) begin
        @(negedge clk);
        to++;
      end
      chk("beat_accept", DW'(s_axis_tready), DW'(1'b1));
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    hdr_valid     = 1'b0;
    exp_pkts++;
  endtask

  task automatic wait_drain();
    int to;
    to = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || m_axis_tvalid) && to < 500) begin
      @(negedge clk);
      to++;
    end
    chk("drain_remaining", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    vt[0] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 8'h04, 3, 0, 1'b0, 1'b0,
              96'h1122334455660A0B0C0D0E0F, 8'h04};
    vt[1] = '{48'hFFFFFFFFFFFF, 48'h000000000000, 8'h80, 1, 0, 1'b0, 1'b0,
              96'h000000000000FFFFFFFFFFFF, 8'h80};
    vt[2] = '{48'h010203040506, 48'hA1A2A3A4A5A6, 8'hFF, 8, 1, 1'b0, 1'b0,
              96'hA1A2A3A4A5A6010203040506, 8'hFF};
    vt[3] = '{48'hDEADBEEF0001, 48'hCAFEF00D0002, 8'h00, 5, 2, 1'b1, 1'b1,
              96'hCAFEF00D0002DEADBEEF0001, 8'h00};

    // Reset state, including readies held low during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_ready", DW'(hdr_ready), DW'(1'b0));
    chk("rst_s_tready", DW'(s_axis_tready), DW'(1'b0));
    chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    chk("rst_m_tdata", m_axis_tdata, DW'(1'b0));
    chk("rst_m_tuser", DW'(m_axis_tuser), DW'(1'b0));
    chk("rst_m_tlast", DW'(m_axis_tlast), DW'(1'b0));
    chk("rst_pkt_count", DW'(pkt_count), DW'(32'd0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hdr_ready", DW'(hdr_ready), DW'(1'b1));
    chk("idle_s_tready", DW'(s_axis_tready), DW'(1'b0));

    // Directed header vectors.
    for (int i = 0; i < 4; i++) begin
      rdy_mode = vt[i].mode;
      cap_seen = 1'b0;
      send_packet(vt[i].dst, vt[i].src, vt[i].port, vt[i].nb, 1'b0, vt[i].noise, vt[i].zk);
      wait_drain();
      chk("vec_first_seen", DW'(cap_seen), DW'(1'b1));
      chk("vec_mac_rewrite", DW'(cap_low96), DW'(vt[i].exp_low96));
      chk("vec_dst_port", DW'(cap_port), DW'(vt[i].exp_port));
      chk("vec_pkt_count", DW'(pkt_count), DW'(exp_pkts));
    end

    // After a single-beat packet, data without a new header must stall.
    rdy_mode = 0;
    send_packet(rand48(), rand48(), 8'h21, 1, 1'b0, 1'b0, 1'b0);
    wait_drain();
    @(posedge clk);
    #1;
    s_axis_tdata  = rand_dw();
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nohdr_s_tready", DW'(s_axis_tready), DW'(1'b0));
      chk("nohdr_hdr_ready", DW'(hdr_ready), DW'(1'b1));
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("nohdr_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));

    // Randomized traffic.
    rdy_mode = 2;
    for (int p = 0; p < 20; p++) begin
      send_packet(rand48(), rand48(), 8'($urandom_range(0, 255)), $urandom_range(1, 6),
                  1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    chk("rand_pkt_count", DW'(pkt_count), DW'(exp_pkts));

    // Reset on the second beat of a five-beat packet.
    mon_en   = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    hdr_dst_mac  = rand48();
    hdr_src_mac  = rand48();
    hdr_dst_port = 8'h5A;
    hdr_valid    = 1'b1;
    @(negedge clk);
    chk("midrst_hdr_ready", DW'(hdr_ready), DW'(1'b1));
    @(posedge clk);
    #1;
    hdr_valid     = 1'b0;
    s_axis_tdata  = rand_dw();
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("midrst_beat0_ready", DW'(s_axis_tready), DW'(1'b1));
    @(posedge clk);
    #1;
    s_axis_tdata = rand_dw();
    reset        = 1'b1;
    @(negedge clk);
    chk("midrst_beat0_out", DW'(m_axis_tvalid), DW'(1'b1));
    chk("midrst_hdr_ready_low", DW'(hdr_ready), DW'(1'b0));
    chk("midrst_s_tready_low", DW'(s_axis_tready), DW'(1'b0));
    @(posedge clk);
    #1;
    reset         = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("postrst_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    chk("postrst_m_tdata", m_axis_tdata, DW'(1'b0));
    chk("postrst_pkt_count", DW'(pkt_count), DW'(32'd0));
    chk("postrst_hdr_ready", DW'(hdr_ready), DW'(1'b1));
    chk("postrst_s_tready", DW'(s_axis_tready), DW'(1'b0));
    exp_q.delete();
    exp_pkts = 0;
    mon_en   = 1'b1;
    cap_seen = 1'b0;
    send_packet(48'h665544332211, 48'hAABBCCDDEEFF, 8'h3C, 3, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("postrst_first_seen", DW'(cap_seen), DW'(1'b1));
    chk("postrst_mac_rewrite", DW'(cap_low96), DW'(96'hAABBCCDDEEFF665544332211));
    chk("postrst_count_one", DW'(pkt_count), DW'(32'd1));

    // Counter wrap from the all-ones value.
    @(negedge clk);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    @(negedge clk);
    chk("wrap_preload", DW'(pkt_count), DW'(32'hFFFF_FFFF));
    send_packet(rand48(), rand48(), 8'h01, 1, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("wrap_to_zero", DW'(pkt_count), DW'(32'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
